// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : load_store_queue
// Purpose  : In-order load/store queue. Issued memory ops wait in a circular
//            FIFO, snoop the writeback broadcast channels for their operands,
//            and are sent one at a time to a single memory port. Stores wait
//            for the ROB head before going out. A flush empties the queue;
//            an in-flight request is then drained without a writeback.
// Ports    : clk_in/rst_in (async, active-high)/rdy_in (global enable)
//            rob_clear      - flush
//            in_*           - issue port, full - back-pressure
//            rob_head_*     - current ROB head, gates store release
//            cdb_*          - CDB_N packed writeback channels (channel k in slice k)
//            lsq_wb_*       - load result pulse, st_done - store completion pulse
//            mem_*          - memory request/response port
//            perf_*         - performance counters
// Config   : LSQ_PERF_EN - when defined, perf_ld/perf_st/perf_stall count;
//            otherwise they are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_queue #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 4,
    parameter int CDB_N = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   rob_clear,
    input  logic                   in_valid,
    input  logic [3:0]             in_type,
    input  logic [ROB_W-1:0]       in_rob_idx,
    input  logic [31:0]            in_r1,
    input  logic [31:0]            in_r2,
    input  logic [ROB_W-1:0]       in_dep1,
    input  logic [ROB_W-1:0]       in_dep2,
    input  logic                   in_has_dep1,
    input  logic                   in_has_dep2,
    input  logic [11:0]            in_offset,
    output logic                   full,
    input  logic                   rob_head_valid,
    input  logic [ROB_W-1:0]       rob_head_idx,
    output logic                   st_done,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] cdb_idx,
    input  logic [CDB_N*32-1:0]    cdb_value,
    output logic                   lsq_wb_valid,
    output logic [ROB_W-1:0]       lsq_wb_idx,
    output logic [31:0]            lsq_wb_value,
    output logic                   mem_valid,
    output logic                   mem_wr,
    output logic [2:0]             mem_len,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_ready,
    input  logic [31:0]            mem_rdata,
    output logic [31:0]            perf_ld,
    output logic [31:0]            perf_st,
    output logic [31:0]            perf_stall
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    // Entry storage
    logic [DEPTH-1:0] r_vld, r_st, r_h1, r_h2;
    logic [2:0]       r_len [DEPTH];
    logic [ROB_W-1:0] r_rob [DEPTH];
    logic [ROB_W-1:0] r_d1  [DEPTH];
    logic [ROB_W-1:0] r_d2  [DEPTH];
    logic [31:0]      r_v1  [DEPTH];
    logic [31:0]      r_v2  [DEPTH];
    logic [11:0]      r_off [DEPTH];

    logic [c_PTR_W-1:0] r_head, r_tail;
    logic [c_CNT_W-1:0] r_count, w_count_nxt;
    logic               r_full;
    logic [1:0]         r_state, w_state_nxt;

    // Registered request and response pulses
    logic [31:0]      r_req_addr, r_req_wdata, r_wb_value;
    logic             r_req_wr, r_wb_valid, r_st_done;
    logic [2:0]       r_req_len;
    logic [ROB_W-1:0] r_req_rob, r_wb_idx;

    logic        w_head_elig, w_launch, w_pop, w_push;
    logic [31:0] w_p1_val, w_p2_val, w_head_addr;
    logic        w_p1_dep, w_p2_dep;

    // Operand capture at issue time: the loop runs high-to-low so the lowest
    // matching channel is the one that sticks.
    always_comb begin
        w_p1_val = in_r1;
        w_p1_dep = in_has_dep1;
        w_p2_val = in_r2;
        w_p2_dep = in_has_dep2;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_valid[k] && in_has_dep1 && cdb_idx[k*ROB_W +: ROB_W] == in_dep1) begin
                w_p1_val = cdb_value[k*32 +: 32];
                w_p1_dep = 1'b0;
            end
            if (cdb_valid[k] && in_has_dep2 && cdb_idx[k*ROB_W +: ROB_W] == in_dep2) begin
                w_p2_val = cdb_value[k*32 +: 32];
                w_p2_dep = 1'b0;
            end
        end
    end

    assign w_head_elig = r_vld[r_head] && !r_h1[r_head] && !r_h2[r_head] &&
                         (!r_st[r_head] || (rob_head_valid && rob_head_idx == r_rob[r_head]));
    assign w_head_addr = r_v1[r_head] + {{20{r_off[r_head][11]}}, r_off[r_head]};

    assign w_launch = rdy_in && !rob_clear && (r_state == c_IDLE) && w_head_elig;
    assign w_pop    = rdy_in && !rob_clear && (r_state == c_BUSY) && mem_ready;
    // A full queue still accepts an issue in the cycle its head retires.
    assign w_push   = rdy_in && !rob_clear && in_valid && (!r_full || w_pop);
    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_vld   <= '0;
            r_st    <= '0;
            r_h1    <= '0;
            r_h2    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_len[i] <= '0;
                r_rob[i] <= '0;
                r_d1[i]  <= '0;
                r_d2[i]  <= '0;
                r_v1[i]  <= '0;
                r_v2[i]  <= '0;
                r_off[i] <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear) begin
                r_vld   <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                // Snoop writebacks for waiting entries (lowest channel wins)
                for (int i = 0; i < DEPTH; i++) begin
                    for (int k = CDB_N - 1; k >= 0; k--) begin
                        if (r_vld[i] && r_h1[i] && cdb_valid[k] &&
                            cdb_idx[k*ROB_W +: ROB_W] == r_d1[i]) begin
                            r_v1[i] <= cdb_value[k*32 +: 32];
                            r_h1[i] <= 1'b0;
                        end
                        if (r_vld[i] && r_h2[i] && cdb_valid[k] &&
                            cdb_idx[k*ROB_W +: ROB_W] == r_d2[i]) begin
                            r_v2[i] <= cdb_value[k*32 +: 32];
                            r_h2[i] <= 1'b0;
                        end
                    end
                end
                if (w_pop) begin
                    r_vld[r_head] <= 1'b0;
                    r_head        <= r_head + c_PTR_W'(1);
                end
                // Placed after the pop so a push into the slot just freed wins
                if (w_push) begin
                    r_vld[r_tail] <= 1'b1;
                    r_st[r_tail]  <= in_type[3];
                    r_len[r_tail] <= in_type[2:0];
                    r_rob[r_tail] <= in_rob_idx;
                    r_d1[r_tail]  <= in_dep1;
                    r_d2[r_tail]  <= in_dep2;
                    r_h1[r_tail]  <= w_p1_dep;
                    r_h2[r_tail]  <= w_p2_dep;
                    r_v1[r_tail]  <= w_p1_val;
                    r_v2[r_tail]  <= w_p2_val;
                    r_off[r_tail] <= in_offset;
                    r_tail        <= r_tail + c_PTR_W'(1);
                end
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == c_CNT_W'(DEPTH));
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state. A flush during BUSY turns the request into a drain
    // unless memory answers in that same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (rdy_in) begin
            case (r_state)
                c_IDLE:  if (w_launch) w_state_nxt = c_BUSY;
                c_BUSY: begin
                    if (rob_clear)      w_state_nxt = mem_ready ? c_IDLE : c_DRAIN;
                    else if (mem_ready) w_state_nxt = c_IDLE;
                end
                c_DRAIN: if (mem_ready) w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        mem_valid = (r_state != c_IDLE);
        mem_wr    = (r_state != c_IDLE) && r_req_wr;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_wr    <= 1'b0;
            r_req_len   <= '0;
            r_req_rob   <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_idx    <= '0;
            r_wb_value  <= '0;
            r_st_done   <= 1'b0;
        end else if (rdy_in) begin
            r_wb_valid <= w_pop && !r_req_wr;
            r_st_done  <= w_pop && r_req_wr;
            if (w_pop && !r_req_wr) begin
                r_wb_value <= mem_rdata;
                r_wb_idx   <= r_req_rob;
            end
            if (w_launch) begin
                r_req_addr  <= w_head_addr;
                r_req_wdata <= r_v2[r_head];
                r_req_wr    <= r_st[r_head];
                r_req_len   <= r_len[r_head];
                r_req_rob   <= r_rob[r_head];
            end
        end
    end

    assign full         = r_full;
    assign st_done      = r_st_done;
    assign lsq_wb_valid = r_wb_valid;
    assign lsq_wb_idx   = r_wb_idx;
    assign lsq_wb_value = r_wb_value;
    assign mem_len      = r_req_len;
    assign mem_addr     = r_req_addr;
    assign mem_wdata    = r_req_wdata;

`ifdef LSQ_PERF_EN
    logic [31:0] r_perf_ld, r_perf_st, r_perf_stall;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_perf_ld    <= '0;
            r_perf_st    <= '0;
            r_perf_stall <= '0;
        end else if (rdy_in) begin
            if (w_pop && !r_req_wr) r_perf_ld <= r_perf_ld + 32'd1;
            if (w_pop && r_req_wr)  r_perf_st <= r_perf_st + 32'd1;
            if (r_state == c_IDLE && r_vld[r_head] && !w_head_elig)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_ld    = r_perf_ld;
    assign perf_st    = r_perf_st;
    assign perf_stall = r_perf_stall;
`else
    assign perf_ld    = '0;
    assign perf_st    = '0;
    assign perf_stall = '0;
`endif

endmodule
`default_nettype wire

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count (power of two, 2..64).
REQ-002 SHALL have parameter ROB_W, default 4, meaning ROB index width.
REQ-003 SHALL have parameter CDB_N, default 2, meaning number of writeback broadcast channels snooped.
REQ-004 SHALL have clk_in  in  1  system clock; the block uses one clock.
REQ-005 SHALL have rst_in  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have rdy_in  in  1  global enable; low freezes all state.
REQ-007 SHALL have rob_clear  in  1  pipeline flush.
REQ-008 SHALL have in_valid  in  1 / in_type  in  4 ({is_store, len[2:0]}) / in_rob_idx  in  ROB_W / in_r1, in_r2  in  32 / in_dep1, in_dep2  in  ROB_W / in_has_dep1, in_has_dep2  in  1 / in_offset  in  12: issue port.
REQ-009 SHALL have full  out  1  queue holds DEPTH entries.
REQ-010 SHALL have rob_head_valid  in  1 / rob_head_idx  in  ROB_W: current ROB head.
REQ-011 SHALL have st_done  out  1  one-cycle pulse when a store completes.
REQ-012 SHALL have cdb_valid  in  CDB_N / cdb_idx  in  CDB_N*ROB_W / cdb_value  in  CDB_N*32: packed writeback channels, channel k in slice k.
REQ-013 SHALL have lsq_wb_valid  out  1 / lsq_wb_idx  out  ROB_W / lsq_wb_value  out  32: load result.
REQ-014 SHALL have mem_valid, mem_wr  out  1 / mem_len  out  3 / mem_addr, mem_wdata  out  32 / mem_ready  in  1 / mem_rdata  in  32: memory port.
REQ-015 SHALL have perf_ld, perf_st, perf_stall  out  32 each: performance counters.

Function
REQ-016 SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH and a count of width log2(DEPTH)+1.
REQ-017 full SHALL equal (count == DEPTH), registered; in_valid while full SHALL be ignored.
REQ-018 Simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH-1 and count == 1.
REQ-019 At push, each operand SHALL capture the matching cdb_value in the same cycle (lowest channel wins on multiple matches) and clear its has_dep flag.
REQ-020 Each cycle, every valid entry waiting on index X SHALL capture cdb_value and clear has_dep when a valid channel carries idx X.
REQ-021 The head SHALL be eligible when valid, both deps clear, and either it is a load, or it is a store and rob_head_valid with rob_head_idx == its rob index.
REQ-022 FSM states SHALL be IDLE, BUSY and DRAIN.
REQ-023 IDLE with an eligible head SHALL register the request (addr = r1 + sign-extended offset, mod 2^32; wdata = r2) and go to BUSY, with mem_valid high from the next cycle.
REQ-024 In BUSY, mem outputs SHALL hold stable until mem_ready, after which head is popped and the state returns to IDLE, with the next request possible no earlier than the following cycle.
REQ-025 On BUSY completion, a load SHALL pulse lsq_wb_valid for one cycle with mem_rdata; a store SHALL pulse st_done for one cycle.
REQ-026 rob_clear SHALL invalidate all entries and zero count, head and tail; if BUSY, the state SHALL go to DRAIN, holding the request until mem_ready, then return to IDLE with no wb or st_done pulse.
REQ-027 rob_clear and push in the same cycle SHALL drop the push.
REQ-028 When rdy_in is low, no state SHALL change and outputs SHALL hold; a mem_ready seen while rdy_in is low SHALL be ignored.

Reset
REQ-029 rst_in SHALL asynchronously clear all entries, pointers, count and counters, set FSM to IDLE, and drive full, st_done, lsq_wb_valid, mem_valid and mem_wr to 0 and all data outputs to 0.
REQ-030 A reset asserted during BUSY or DRAIN SHALL abandon the request immediately.

Configuration
REQ-031 With LSQ_PERF_EN defined: perf_ld/perf_st SHALL count completed loads/stores, and perf_stall SHALL count cycles where the head is valid but not eligible in IDLE; all counters SHALL wrap at 2^32 and freeze when rdy_in is low.
REQ-032 Without LSQ_PERF_EN, perf_* SHALL be tied to 0 and no counter registers SHALL exist.

Verification
REQ-033 Push load r1=0x1000, offset=-4, len=2, no deps -> mem_valid next cycle, addr 0x0FFC; mem_ready, rdata 0xDEADBEEF -> lsq_wb_valid one cycle, value 0xDEADBEEF.
REQ-034 Push store with dep2=3 pending; cdb channel 1 idx 3 value 0x55 -> entry waits until rob_head_idx matches, mem_wr=1, wdata 0x55; mem_ready -> st_done one cycle.
REQ-035 Push DEPTH entries -> full=1, extra push ignored; pop and push in the same cycle -> full stays 1, count == DEPTH.
REQ-036 rob_clear while BUSY on a load -> queue empty, mem_valid held until mem_ready, no lsq_wb_valid; next push serviced normally.
REQ-037 rdy_in low for 5 cycles during BUSY with mem_ready high -> no pop, outputs frozen; with LSQ_PERF_EN, perf counters unchanged.
REQ-038 Assert rst_in mid-BUSY, asynchronously between edges -> mem_valid, full and count 0 before the next clock edge.
